// File: rtl/prog_timer.sv
// ============================================================================
// Module   : prog_timer
// Brief    : Programmable interval timer (IDLE/RUN/DONE) with one-shot and
//            auto-reload modes. Define PROG_TIMER_PRESCALE_EN to add a
//            clock prescaler and the prescale_i port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_timer #(
    parameter int WIDTH      = 16,
    parameter int DEFAULT_TC = 39999,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic                  hold_i,
    input  logic                  periodic_i,
    input  logic                  load_tc_i,
    input  logic [WIDTH-1:0]      tc_in_i,
`ifdef PROG_TIMER_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] prescale_i,
`endif
    output logic [WIDTH-1:0]      count_o,
    output logic                  tick_o,
    output logic                  expired_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   tc_q, tc_d;
    logic               tick_q, tick_d;
    logic               busy_q, busy_d;
    logic               expired_q, expired_d;
    logic               w_adv_en;
    logic               w_terminal;

`ifdef PROG_TIMER_PRESCALE_EN
    logic [PRESCALE_W-1:0] presc_q, presc_d;

    // >= keeps the divider from stalling if prescale_i is lowered mid-count.
    assign w_adv_en = (presc_q >= prescale_i);
`else
    if (PRESCALE_W < 1) begin : g_pw_check
        $error("PRESCALE_W must be at least 1");
    end
    assign w_adv_en = 1'b1;
`endif

    // All-ones also terminates so the counter can never wrap.
    assign w_terminal = (count_q >= tc_q) || (count_q == {WIDTH{1'b1}});

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tick_d  = 1'b0;
        tc_d    = load_tc_i ? tc_in_i : tc_q;
`ifdef PROG_TIMER_PRESCALE_EN
        presc_d = presc_q;
`endif
        if (stop_i) begin
            state_d = IDLE;
            count_d = '0;
`ifdef PROG_TIMER_PRESCALE_EN
            presc_d = '0;
`endif
        end else if (start_i) begin
            state_d = RUN;
            count_d = '0;
`ifdef PROG_TIMER_PRESCALE_EN
            presc_d = '0;
`endif
        end else if ((state_q == RUN) && !hold_i) begin
`ifdef PROG_TIMER_PRESCALE_EN
            presc_d = w_adv_en ? '0 : presc_q + 1'b1;
`endif
            if (w_adv_en) begin
                if (w_terminal) begin
                    tick_d = 1'b1;
                    if (periodic_i) begin
                        count_d = '0;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
        end
        busy_d    = (state_d == RUN);
        expired_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            tc_q      <= WIDTH'(DEFAULT_TC);
            tick_q    <= 1'b0;
            busy_q    <= 1'b0;
            expired_q <= 1'b0;
`ifdef PROG_TIMER_PRESCALE_EN
            presc_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            tc_q      <= tc_d;
            tick_q    <= tick_d;
            busy_q    <= busy_d;
            expired_q <= expired_d;
`ifdef PROG_TIMER_PRESCALE_EN
            presc_q   <= presc_d;
`endif
        end
    end

    assign count_o   = count_q;
    assign tick_o    = tick_q;
    assign busy_o    = busy_q;
    assign expired_o = expired_q;

endmodule

`default_nettype wire

// File: doc/prog_timer.md
PROG_TIMER -- requirements
Module: prog_timer

Interface
REQ-001 Parameter WIDTH, default 16: counter and terminal-count width in bits.
REQ-002 Parameter DEFAULT_TC, default 39999: terminal count loaded at reset (8 ms at 5 MHz).
REQ-003 Parameter PRESCALE_W, default 8: prescaler width; used only when PROG_TIMER_PRESCALE_EN is defined.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active high.
REQ-006 start  input  1  begin or restart a timing run.
REQ-007 stop  input  1  abort the run and return to idle.
REQ-008 hold  input  1  while high, freeze the count in RUN.
REQ-009 periodic  input  1  1 = auto-reload mode, 0 = one-shot; sampled on each terminal event.
REQ-010 load_tc  input  1  write tc_in into the terminal-count register.
REQ-011 tc_in  input  WIDTH  new terminal count.
REQ-012 prescale  input  PRESCALE_W  divide value N; the count advances every N+1 clocks (macro only).
REQ-013 count  output  WIDTH  current count value.
REQ-014 tick  output  1  one-cycle pulse per terminal event.
REQ-015 expired  output  1  high in DONE (one-shot complete).
REQ-016 busy  output  1  high in RUN.

Function
REQ-017 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-018 Priority SHALL be stop > start > hold/advance; stop in any state SHALL go to IDLE, clear count and clear the prescaler.
REQ-019 start in any state without stop SHALL go to RUN with count=0; a start sampled at edge k gives count=0 at cycle k+1.
REQ-020 In RUN, with hold=0 and an advance enable asserted, count SHALL increment by 1 on each edge; hold=1 SHALL freeze count and the prescaler.
REQ-021 A terminal event SHALL occur on an advancing RUN edge where count >= tc_reg; >= rather than == ensures that lowering tc below count cannot overrun.
REQ-022 On a terminal event, tick SHALL be 1 in the following cycle only.
- periodic=1: count SHALL go to 0 and the FSM SHALL stay in RUN, giving period (tc_reg+1)*(prescale+1) clocks.
- periodic=0: the FSM SHALL go to DONE with count held at its terminal value.
REQ-023 With tc_reg=0, every advancing RUN edge SHALL be a terminal event.
REQ-024 count SHALL never wrap: at 2^WIDTH-1 a terminal event SHALL occur regardless of tc_reg.
REQ-025 load_tc SHALL update tc_reg on the same edge in any state; comparisons from the next edge SHALL use the new value.
REQ-026 When load_tc and a terminal compare coincide, the compare SHALL use the old tc_reg.
REQ-027 DONE SHALL be left only by start (to RUN) or stop (to IDLE); count SHALL hold in IDLE and DONE.
REQ-028 busy SHALL equal (state==RUN) and expired SHALL equal (state==DONE); both SHALL be registered with no combinational input-to-output path.

Reset
REQ-029 Asserting rst SHALL immediately force state=IDLE, count=0, tc_reg=DEFAULT_TC, prescaler=0, tick=0, expired=0 and busy=0, including mid-run.
REQ-030 After rst deasserts, the block SHALL ignore nothing: a start on the first clock edge SHALL be honoured.

Configuration
REQ-031 With PROG_TIMER_PRESCALE_EN defined, the prescale port and prescaler counter SHALL exist, and the advance enable SHALL assert once every prescale+1 non-held RUN clocks.
- The prescaler SHALL clear on start, stop and every terminal event.
- prescale=0 SHALL behave identically to the macro-undefined build.
REQ-032 Without PROG_TIMER_PRESCALE_EN, the prescale port and logic SHALL be absent and the advance enable SHALL be constant 1.

Verification
REQ-033 Reset, no load, one-shot, start at edge 0: count reaches 39999, tick high for exactly one cycle at cycle 40001, then expired=1, busy=0 and count holds 39999.
REQ-034 load_tc with tc_in=3, periodic=1, start: tick every 4 clocks, count sequence 0,1,2,3,0...; stop: count=0, busy=0, no further ticks.
REQ-035 tc=10, run to count=7, load tc_in=5: terminal event on the next advancing edge (7>=5), tick the cycle after.
REQ-036 tc=5, hold high for 20 cycles at count=2: count stays 2, no tick; release: tick after 4 more edges; start and stop asserted together: IDLE.
REQ-037 Macro defined, prescale=2, tc=1, periodic: tick every 6 clocks; rst asserted mid-run between edges: outputs clear immediately, tc_reg returns to 39999.
